rc522_spi_responder: RTL and testbench
======================================

// Module: rc522_spi_responder
// PURPOSE
//  SPI-slave model of the MFRC522 register interface; the target end of the SPI link driven by
//  our RC522 controller. Decodes RC522 address/data framing and serves a 64x8 register file with
//  a FIFODataReg-backed byte FIFO. Local logic can preload the FIFO (e.g. with UID bytes) and is
//  notified of CommandReg writes. Used in the bench and on FPGA for loopback bring-up.
// PARAMETERS
//  FIFO_DEPTH   16     FIFO entries; power of two, 2..64
//  VERSION      8'h92  value returned by VersionReg (0x37)
// PORTS
//  clk              in   1  system clock; must be >= 8x sck frequency
//  rst              in   1  synchronous, active-high reset
//  cs_n             in   1  SPI chip select, active low (async, synchronized internally)
//  sck              in   1  SPI clock, mode 0 (async, synchronized internally)
//  mosi             in   1  SPI data in, MSB first
//  miso             out  1  SPI data out, MSB first
//  miso_oe          out  1  1 while cs_n (synced) is low; tri-state enable for miso
//  push_valid       in   1  local FIFO push request
//  push_data        in   8  local FIFO push byte
//  push_ready       out  1  = !fifo_full && no SPI FIFO write this cycle
//  cmd_valid        out  1  one-cycle pulse on completed SPI write to CommandReg (0x01)
//  cmd_code         out  4  data[3:0] of that write; held until next cmd_valid
//  fifo_level       out  7  current FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, cmd_valid=0, cmd_code=0, FIFO empty, all registers 0x00, bit/byte counters 0.
//  Sync: cs_n, sck, mosi each through 2 FFs; sck edges detected on synced value (2-3 clk latency).
//  Frame: synced cs_n falling -> bit_cnt=0, byte_idx=0, tx_shift=0x00. cs_n high -> idle, miso_oe=0.
//  sck rise: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++ (3-bit, wraps 7->0 = byte complete).
//  sck fall: if bit_cnt!=0 tx_shift <<= 1. miso = tx_shift[7] combinationally from register.
//  Byte 0: rw=rx[7] (1=read), addr=rx[6:1]; rx[0] ignored. Read -> tx_shift loaded with data(addr).
//  Read, byte_idx>=1: rx[6:1] is next address, tx_shift loaded with data(next); rx[7] ignored.
//    MISO in byte 0 is 0x00; MISO in byte n is data for address sent in byte n-1.
//  Write, byte_idx>=1: rx is data for addr (same addr for whole burst). MISO outputs 0x00.
//  Load of tx_shift occurs in the clk cycle after byte complete, before next sck fall.
//  Register map (others: plain R/W storage):
//   0x01 CommandReg  write stores byte, pulses cmd_valid next cycle, cmd_code=data[3:0]
//   0x06 ErrorReg    bit4 BufferOvfl set on any dropped FIFO push; write clears written-1 bits
//   0x09 FIFODataReg read pops head (empty -> 0x00, no state change); write pushes
//   0x0A FIFOLevelReg read {1'b0, level}; write with bit7=1 flushes FIFO and clears ErrorReg bit4
//   0x37 VersionReg  read VERSION; writes ignored
//  FIFO: SPI write has priority over local push in the same cycle (push_ready=0 that cycle).
//   Push when full -> byte dropped, BufferOvfl set. Pop and push same cycle -> level unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  cs_n rising mid-byte: partial byte discarded, no write, no pop, counters cleared.
//  rst mid-transaction: all state to reset values; next frame needs fresh cs_n fall.
// TESTING
//  Read 0x37: MOSI {0xEE,0x00} -> MISO {0x00,0x92}; no state change.
//  Write 0x01: MOSI {0x02,0x0C} -> one cmd_valid pulse, cmd_code=4'hC, read-back 0x0C.
//  Local push 0xDE,0xAD,0xBE,0xEF; MOSI {0x94,0x92,0x92,0x92,0x00} -> MISO {0x00,0x04,0xDE,0xAD,0xBE}; level=1.
//  Fill FIFO to 16, SPI write 0x12 -> level 16, ErrorReg=0x10; write 0x0A=0x80 -> level 0, ErrorReg 0x00.
//  Same-cycle SPI FIFO write and push_valid -> push_ready=0, only SPI byte stored.
//  cs_n raised after 5 bits of a write to 0x01 -> no cmd_valid, register unchanged; next frame normal.

Source files
------------

// File: rtl/rc522_spi_responder.sv
// SPI-slave model of the MFRC522 register interface: 64x8 register file, FIFODataReg-backed
// byte FIFO with a local preload port, and CommandReg write notification.
module rc522_spi_responder #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  VERSION    = 8'h92
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       push_valid,
    input  logic [7:0] push_data,
    output logic       push_ready,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    output logic [6:0] fifo_level
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = 7;

    localparam logic [5:0] ADDR_CMD  = 6'h01;
    localparam logic [5:0] ADDR_ERR  = 6'h06;
    localparam logic [5:0] ADDR_FIFO = 6'h09;
    localparam logic [5:0] ADDR_LVL  = 6'h0A;
    localparam logic [5:0] ADDR_VER  = 6'h37;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cs_sync, sck_sync;
    logic [1:0]      mosi_sync;
    logic [2:0]      bit_cnt;
    logic            hdr_done, rw_q;
    logic [5:0]      addr_q;
    logic [7:0]      rx_shift, tx_shift;
    logic [7:0]      regs [64];
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;

    logic            cs_s, cs_fall, sck_rise, sck_fall;
    logic            frame_start, frame_end, commit;
    logic            do_read, do_write, spi_push, spi_pop, flush;
    logic            fifo_full, fifo_empty, local_push, push_en, ovfl_set;
    logic [5:0]      rd_addr;
    logic [7:0]      rd_data, push_byte;
    logic [PW-1:0]   mem_waddr;

    assign cs_s     = cs_sync[1];
    assign cs_fall  = cs_sync[2] & ~cs_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];

    assign frame_start = (state_q == ST_IDLE) && cs_fall;
    assign frame_end   = (state_q != ST_IDLE) && cs_s;
    assign commit      = (state_q == ST_COMMIT) && !cs_s;

    // Byte 0 carries rw/addr; later bytes are either next read address or write data.
    assign rd_addr  = rx_shift[6:1];
    assign do_read  = commit && (hdr_done ? rw_q : rx_shift[7]);
    assign do_write = commit && hdr_done && !rw_q;

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign spi_push   = do_write && (addr_q == ADDR_FIFO);
    assign spi_pop    = do_read && (rd_addr == ADDR_FIFO) && !fifo_empty;
    assign flush      = do_write && (addr_q == ADDR_LVL) && rx_shift[7];
    assign push_ready = !fifo_full && !spi_push;
    assign local_push = push_valid && push_ready;
    assign push_en    = local_push || (spi_push && !fifo_full);
    assign push_byte  = spi_push ? rx_shift : push_data;
    assign ovfl_set   = (spi_push || push_valid) && fifo_full;
    assign mem_waddr  = flush ? '0 : wr_ptr;

    assign miso       = tx_shift[7];
    assign fifo_level = level;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[1:0], cs_n};
            sck_sync  <= {sck_sync[1:0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    // Frame state register and output enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            miso_oe <= 1'b0;
        end else begin
            state_q <= state_d;
            miso_oe <= (state_d != ST_IDLE);
        end
    end

    // Next-state: a fresh cs_n fall opens a frame, each 8th sck rise commits a byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_s)                               state_d = ST_IDLE;
                else if (sck_rise && bit_cnt == 3'd7)  state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = cs_s ? ST_IDLE : ST_SHIFT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read data mux for the tx_shift load.
    always_comb begin
        rd_data = regs[rd_addr];
        case (rd_addr)
            ADDR_FIFO: rd_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
            ADDR_LVL:  rd_data = {1'b0, level};
            ADDR_VER:  rd_data = VERSION;
            default:   ;
        endcase
    end

    // Shift registers, bit counter and per-frame header capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            hdr_done <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (frame_start || frame_end) begin
            bit_cnt  <= '0;
            hdr_done <= 1'b0;
            tx_shift <= '0;
        end else if (state_q == ST_SHIFT) begin
            if (sck_rise) begin
                rx_shift <= {rx_shift[6:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (sck_fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
        end else if (commit) begin
            hdr_done <= 1'b1;
            if (!hdr_done) begin
                rw_q   <= rx_shift[7];
                addr_q <= rx_shift[6:1];
            end
            tx_shift <= do_read ? rd_data : 8'h00;
        end
    end

    // Register file writes, ErrorReg overflow flag and CommandReg notification.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
        end else begin
            cmd_valid <= do_write && (addr_q == ADDR_CMD);
            if (do_write) begin
                case (addr_q)
                    ADDR_CMD: begin
                        regs[ADDR_CMD] <= rx_shift;
                        cmd_code       <= rx_shift[3:0];
                    end
                    ADDR_ERR:                     regs[ADDR_ERR] <= regs[ADDR_ERR] & ~rx_shift;
                    ADDR_FIFO, ADDR_LVL, ADDR_VER: ;
                    default:                      regs[addr_q] <= rx_shift;
                endcase
            end
            if (flush)    regs[ADDR_ERR][4] <= 1'b0;
            if (ovfl_set) regs[ADDR_ERR][4] <= 1'b1;
        end
    end

    // FIFO storage; a flush with a same-cycle local push restarts at slot 0.
    always_ff @(posedge clk) begin
        if (push_en) fifo_mem[mem_waddr] <= push_byte;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= local_push ? PW'(1) : '0;
            level  <= local_push ? LW'(1) : '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (spi_pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(push_en) - LW'(spi_pop);
        end
    end

endmodule

// File: tb/tb_rc522_spi_responder.sv
// Bench for rc522_spi_responder: directed vector table, hand-written corner sequences,
// then random frames checked against a register/FIFO reference model.
module tb_rc522_spi_responder;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst, cs_n, sck, mosi, miso, miso_oe;
    logic       push_valid, push_ready, cmd_valid;
    logic [7:0] push_data;
    logic [3:0] cmd_code;
    logic [6:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cmd_pulses = 0;

    rc522_spi_responder #(.FIFO_DEPTH(16), .VERSION(8'h92)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Count cycles with cmd_valid high.
    always @(negedge clk) if (!rst && cmd_valid) cmd_pulses = cmd_pulses + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] f_mosi [8];
    logic [7:0] f_miso [8];
    logic       f_oe;

    // Raise push_valid in the cycle push_ready drops during an SPI FIFO write.
    task automatic collide_watch();
        bit seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (!push_ready) begin
                seen = 1'b1;
                push_valid = 1'b1;
                push_data  = 8'h77;
                @(negedge clk);
                push_valid = 1'b0;
            end
        end
        check("collide_ready_low", 32'(seen), 32'd1);
    endtask

    // SPI mode-0 master: last byte may be cut short to last_bits.
    task automatic spi_frame(input int nbytes, input int last_bits, input bit collide);
        f_oe = 1'b1;
        cs_n = 1'b0;
        step(6);
        for (int b = 0; b < nbytes; b++) begin
            int nb = (b == nbytes - 1) ? last_bits : 8;
            f_miso[b] = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = f_mosi[b][7-i];
                step(H);
                f_miso[b] = {f_miso[b][6:0], miso};
                f_oe = f_oe & miso_oe;
                sck = 1'b1;
                if (collide && b == nbytes - 1 && i == 7) collide_watch();
                step(H);
                sck = 1'b0;
            end
        end
        step(H);
        cs_n = 1'b1;
        step(6);
    endtask

    task automatic frame2(input logic [7:0] a, input logic [7:0] b);
        f_mosi[0] = a;
        f_mosi[1] = b;
        spi_frame(2, 8, 1'b0);
    endtask

    task automatic lpush(input logic [7:0] d);
        @(negedge clk);
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    typedef struct {
        int                npush;
        logic [0:3][7:0]   push;
        int                n;
        logic [0:4][7:0]   mo;
        logic [0:4][7:0]   mi;
        int                lvl;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic set_vec(input int idx, input int np, input logic [0:3][7:0] pu, input int n,
                           input logic [0:4][7:0] mo, input logic [0:4][7:0] mi, input int lvl);
        vecs[idx].npush = np;
        vecs[idx].push  = pu;
        vecs[idx].n     = n;
        vecs[idx].mo    = mo;
        vecs[idx].mi    = mi;
        vecs[idx].lvl   = lvl;
    endtask

    // Reference model: register contents, ErrorReg, FIFO queue, command notifications.
    logic [7:0] m_regs [64];
    logic [7:0] m_err;
    logic [7:0] m_fifo [$];
    int         m_pulses;
    logic [3:0] m_code;

    task automatic m_read(input logic [5:0] a, output logic [7:0] d);
        case (a)
            6'h09:   d = (m_fifo.size() > 0) ? m_fifo.pop_front() : 8'h00;
            6'h0A:   d = 8'(m_fifo.size());
            6'h37:   d = 8'h92;
            6'h06:   d = m_err;
            default: d = m_regs[a];
        endcase
    endtask

    task automatic m_push(input logic [7:0] d);
        if (m_fifo.size() < 16) m_fifo.push_back(d);
        else m_err = m_err | 8'h10;
    endtask

    task automatic m_write(input logic [5:0] a, input logic [7:0] d);
        case (a)
            6'h01: begin m_regs[1] = d; m_pulses++; m_code = d[3:0]; end
            6'h06: m_err = m_err & ~d;
            6'h09: m_push(d);
            6'h0A: if (d[7]) begin m_fifo.delete(); m_err = m_err & ~8'h10; end
            6'h37: ;
            default: m_regs[a] = d;
        endcase
    endtask

    function automatic logic [5:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 6'h01;
            1: return 6'h06;
            2, 3: return 6'h09;
            4: return 6'h0A;
            5: return 6'h37;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int p, base;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        push_valid = 1'b0; push_data = 8'h00;
        step(4);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        step(4);

        set_vec(0, 0, '0, 2, {8'hEE, 8'h00, 24'h0}, {8'h00, 8'h92, 24'h0}, 0);
        set_vec(1, 0, '0, 2, {8'h02, 8'h0C, 24'h0}, {8'h00, 8'h00, 24'h0}, 0);
        set_vec(2, 0, '0, 2, {8'h82, 8'h00, 24'h0}, {8'h00, 8'h0C, 24'h0}, 0);
        set_vec(3, 4, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 5, {8'h94, 8'h92, 8'h92, 8'h92, 8'h00},
                {8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE}, 1);
        set_vec(4, 0, '0, 2, {8'h14, 8'h80, 24'h0}, {8'h00, 8'h00, 24'h0}, 0);
        set_vec(5, 0, '0, 2, {8'h8C, 8'h00, 24'h0}, {8'h00, 8'h00, 24'h0}, 0);
        set_vec(6, 0, '0, 3, {8'h40, 8'h11, 8'h22, 16'h0}, {8'h00, 8'h00, 8'h00, 16'h0}, 0);
        set_vec(7, 0, '0, 3, {8'hC0, 8'hC0, 8'h00, 16'h0}, {8'h00, 8'h22, 8'h22, 16'h0}, 0);

        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < vecs[v].npush; k++) lpush(vecs[v].push[k]);
            for (int k = 0; k < vecs[v].n; k++) f_mosi[k] = vecs[v].mo[k];
            spi_frame(vecs[v].n, 8, 1'b0);
            for (int k = 0; k < vecs[v].n; k++)
                check($sformatf("vec%0d_miso%0d", v, k), 32'(f_miso[k]), 32'(vecs[v].mi[k]));
            check($sformatf("vec%0d_oe", v), 32'(f_oe), 32'd1);
            check($sformatf("vec%0d_level", v), 32'(fifo_level), 32'(vecs[v].lvl));
        end
        check("cmd_pulse_count", 32'(cmd_pulses), 32'd1);
        check("cmd_code_c", 32'(cmd_code), 32'hC);

        // Full FIFO: SPI write dropped, flag set, flush clears both.
        for (int i = 0; i < 16; i++) lpush(8'(i + 1));
        check("fill_level", 32'(fifo_level), 32'd16);
        @(negedge clk);
        check("full_ready", 32'(push_ready), 32'd0);
        frame2(8'h12, 8'h55);
        check("spi_drop_level", 32'(fifo_level), 32'd16);
        frame2(8'h8C, 8'h00);
        check("spi_drop_err", 32'(f_miso[1]), 32'h10);
        frame2(8'h14, 8'h80);
        check("flush_level", 32'(fifo_level), 32'd0);
        frame2(8'h8C, 8'h00);
        check("flush_err", 32'(f_miso[1]), 32'h00);

        // Local push into a full FIFO.
        for (int i = 0; i < 17; i++) lpush(8'(i + 1));
        check("local_drop_level", 32'(fifo_level), 32'd16);
        frame2(8'h8C, 8'h00);
        check("local_drop_err", 32'(f_miso[1]), 32'h10);
        frame2(8'h92, 8'h00);
        check("full_head", 32'(f_miso[1]), 32'h01);
        check("full_pop_level", 32'(fifo_level), 32'd15);
        frame2(8'h14, 8'h80);

        // SPI FIFO write colliding with a local push.
        f_mosi[0] = 8'h12;
        f_mosi[1] = 8'h5A;
        spi_frame(2, 8, 1'b1);
        check("collide_level", 32'(fifo_level), 32'd1);
        frame2(8'h92, 8'h00);
        check("collide_data", 32'(f_miso[1]), 32'h5A);
        check("collide_empty", 32'(fifo_level), 32'd0);

        // cs_n raised mid-byte on a CommandReg write.
        p = cmd_pulses;
        f_mosi[0] = 8'h02;
        f_mosi[1] = 8'h0F;
        spi_frame(2, 5, 1'b0);
        check("abort_no_cmd", 32'(cmd_pulses), 32'(p));
        frame2(8'h82, 8'h00);
        check("abort_reg_kept", 32'(f_miso[1]), 32'h0C);
        frame2(8'h02, 8'h03);
        check("after_abort_cmd", 32'(cmd_pulses), 32'(p + 1));
        check("after_abort_code", 32'(cmd_code), 32'h3);
        frame2(8'h82, 8'h00);
        check("after_abort_reg", 32'(f_miso[1]), 32'h03);

        // Reset in the middle of a frame.
        lpush(8'h11);
        lpush(8'h22);
        cs_n = 1'b0;
        step(6);
        mosi = 1'b1;
        for (int i = 0; i < 3; i++) begin step(H); sck = 1'b1; step(H); sck = 1'b0; end
        rst = 1'b1;
        step(2);
        check("midrst_oe", 32'(miso_oe), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_code", 32'(cmd_code), 32'd0);
        rst = 1'b0;
        step(6);
        check("midrst_no_fresh_fall", 32'(miso_oe), 32'd0);
        cs_n = 1'b1;
        mosi = 1'b0;
        step(6);
        frame2(8'h82, 8'h00);
        check("midrst_reg_cleared", 32'(f_miso[1]), 32'h00);

        // Random frames against the reference model, starting from reset contents.
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_err = 8'h00;
        m_fifo.delete();
        m_pulses = 0;
        m_code = 4'h0;
        base = cmd_pulses;
        for (int it = 0; it < 40; it++) begin
            logic       rw;
            logic [5:0] a, cur;
            logic [7:0] d;
            logic [7:0] exp [5];
            int         nd, np;
            if ($urandom_range(0, 2) == 0) begin
                np = $urandom_range(1, 6);
                for (int k = 0; k < np; k++) begin
                    d = 8'($urandom);
                    lpush(d);
                    m_push(d);
                end
            end
            rw = 1'($urandom);
            a  = pick_addr();
            nd = $urandom_range(1, 3);
            f_mosi[0] = {rw, a, 1'($urandom)};
            for (int i = 1; i <= nd; i++) begin
                if (rw) f_mosi[i] = {1'($urandom), pick_addr(), 1'($urandom)};
                else begin
                    d = 8'($urandom);
                    if (a == 6'h0A && $urandom_range(0, 3) != 0) d[7] = 1'b0;
                    f_mosi[i] = d;
                end
            end
            exp[0] = 8'h00;
            cur = a;
            for (int i = 1; i <= nd; i++) begin
                if (rw) begin
                    m_read(cur, exp[i]);
                    cur = f_mosi[i][6:1];
                end else begin
                    exp[i] = 8'h00;
                    m_write(a, f_mosi[i]);
                end
            end
            if (rw) m_read(cur, d);
            spi_frame(nd + 1, 8, 1'b0);
            for (int i = 0; i <= nd; i++)
                check($sformatf("rnd%0d_miso%0d", it, i), 32'(f_miso[i]), 32'(exp[i]));
            check($sformatf("rnd%0d_level", it), 32'(fifo_level), 32'(m_fifo.size()));
            check($sformatf("rnd%0d_cmds", it), 32'(cmd_pulses - base), 32'(m_pulses));
            check($sformatf("rnd%0d_code", it), 32'(cmd_code), 32'(m_code));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
